// File: rtl/dcache_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_req_ctrl
// Brief    : Issues one load/store/AMO at a time onto the data-cache port, with
//            NACK backoff, tag filtering, kill and exception capture.
//            Optional WAIT watchdog: define DCACHE_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module dcache_req_ctrl #(
  parameter int NACK_BACKOFF   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  input  logic [1:0]  req_mem_op_i,
  input  logic [4:0]  req_cmd_i,
  input  logic [39:0] req_addr_i,
  input  logic [3:0]  req_op_type_i,
  input  logic [63:0] req_data_i,
  input  logic [4:0]  req_rd_i,
  input  logic        kill_i,
  input  logic        dmem_req_ready_i,
  input  logic        dmem_resp_valid_i,
  input  logic        dmem_resp_replay_i,
  input  logic        dmem_resp_nack_i,
  input  logic [7:0]  dmem_resp_tag_i,
  input  logic [63:0] dmem_resp_data_i,
  input  logic [3:0]  dmem_xcpt_i,
  output logic        dmem_req_valid_o,
  output logic [4:0]  dmem_req_cmd_o,
  output logic [39:0] dmem_req_addr_o,
  output logic [3:0]  dmem_op_type_o,
  output logic [63:0] dmem_req_data_o,
  output logic [7:0]  dmem_req_tag_o,
  output logic        dmem_req_invalidate_lr_o,
  output logic        dmem_req_kill_o,
  output logic        dmem_lock_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [63:0] done_data_o,
  output logic [4:0]  done_rd_o,
  output logic        xcpt_valid_o,
  output logic [3:0]  xcpt_code_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_BACKOFF = 2'd3
  } state_t;

  localparam logic [1:0]  c_OP_STORE = 2'd1;
  localparam logic [1:0]  c_OP_AMO   = 2'd2;
  localparam int unsigned c_BO_W     = (NACK_BACKOFF > 1) ? $clog2(NACK_BACKOFF) : 1;
  localparam logic [c_BO_W-1:0] c_BO_LOAD = (NACK_BACKOFF > 0) ? c_BO_W'(NACK_BACKOFF - 1) : '0;

  state_t             r_state, w_next_state;
  logic [2:0]         r_seq, r_tag_seq;
  logic [1:0]         r_mem_op;
  logic [4:0]         r_cmd, r_rd;
  logic [39:0]        r_addr;
  logic [3:0]         r_op_type;
  logic [63:0]        r_data;
  logic [c_BO_W-1:0]  r_bo_cnt;
  logic               r_done, r_xcpt_valid;
  logic [63:0]        r_done_data;
  logic [4:0]         r_done_rd;
  logic [3:0]         r_xcpt_code;

  logic               w_capture, w_is_amo, w_match, w_timeout;
  logic               w_kill_pulse, w_fin, w_fin_xcpt;
  logic [3:0]         w_fin_code;
  logic [63:0]        w_fin_data;

  // The instruction still presented during the done_o cycle is the one just retired.
  assign w_capture = (r_state == S_IDLE) & req_valid_i & ~r_done & ~kill_i;
  assign w_is_amo  = (r_mem_op == c_OP_AMO);
  assign w_match   = (dmem_resp_valid_i | dmem_resp_replay_i) &
                     (dmem_resp_tag_i == {r_tag_seq, r_rd});

`ifdef DCACHE_TIMEOUT_EN
  localparam int unsigned c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);
  logic [c_TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_to_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_to_cnt <= r_to_cnt + c_TO_W'(1);
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == S_WAIT) & (r_to_cnt == c_TO_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_kill_pulse = 1'b0;
    w_fin        = 1'b0;
    w_fin_xcpt   = 1'b0;
    w_fin_code   = 4'd0;
    w_fin_data   = 64'd0;
    case (r_state)
      S_IDLE: begin
        if (w_capture) w_next_state = S_REQ;
      end
      S_REQ: begin
        if (kill_i)                w_next_state = S_IDLE;
        else if (dmem_req_ready_i) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (kill_i) begin
          w_kill_pulse = 1'b1;
          w_next_state = S_IDLE;
        end else if (|dmem_xcpt_i) begin
          w_fin        = 1'b1;
          w_fin_xcpt   = 1'b1;
          w_fin_code   = dmem_xcpt_i;
          w_next_state = S_IDLE;
        end else if (w_timeout) begin
          w_kill_pulse = 1'b1;
          w_fin        = 1'b1;
          w_fin_xcpt   = 1'b1;
          w_fin_code   = 4'b1111;
          w_next_state = S_IDLE;
        end else if (dmem_resp_nack_i) begin
          w_next_state = (NACK_BACKOFF == 0) ? S_REQ : S_BACKOFF;
        end else if (w_match) begin
          w_fin        = 1'b1;
          w_fin_data   = (r_mem_op == c_OP_STORE) ? 64'd0 : dmem_resp_data_i;
          w_next_state = S_IDLE;
        end
      end
      S_BACKOFF: begin
        if (kill_i) begin
          w_kill_pulse = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_bo_cnt == '0) begin
          w_next_state = S_REQ;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_seq        <= 3'd0;
      r_tag_seq    <= 3'd0;
      r_mem_op     <= 2'd0;
      r_cmd        <= 5'd0;
      r_rd         <= 5'd0;
      r_addr       <= 40'd0;
      r_op_type    <= 4'd0;
      r_data       <= 64'd0;
      r_bo_cnt     <= '0;
      r_done       <= 1'b0;
      r_xcpt_valid <= 1'b0;
      r_done_data  <= 64'd0;
      r_done_rd    <= 5'd0;
      r_xcpt_code  <= 4'd0;
    end else begin
      r_done       <= w_fin;
      r_xcpt_valid <= w_fin_xcpt;
      if (w_fin) begin
        r_done_data <= w_fin_data;
        r_done_rd   <= r_rd;
        r_xcpt_code <= w_fin_code;
      end
      // Each capture gets a fresh seq so late responses to killed requests miss.
      if (w_capture) begin
        r_mem_op  <= req_mem_op_i;
        r_cmd     <= req_cmd_i;
        r_rd      <= req_rd_i;
        r_addr    <= req_addr_i;
        r_op_type <= req_op_type_i;
        r_data    <= req_data_i;
        r_tag_seq <= r_seq;
        r_seq     <= r_seq + 3'd1;
      end
      if (r_state == S_WAIT) begin
        r_bo_cnt <= c_BO_LOAD;
      end else if ((r_state == S_BACKOFF) && (r_bo_cnt != '0)) begin
        r_bo_cnt <= r_bo_cnt - c_BO_W'(1);
      end
    end
  end

  assign dmem_req_valid_o         = (r_state == S_REQ);
  assign dmem_req_cmd_o           = r_cmd;
  assign dmem_req_addr_o          = r_addr;
  assign dmem_op_type_o           = r_op_type;
  assign dmem_req_data_o          = r_data;
  assign dmem_req_tag_o           = {r_tag_seq, r_rd};
  assign dmem_req_kill_o          = w_kill_pulse;
  assign dmem_req_invalidate_lr_o = w_kill_pulse & w_is_amo;
  assign dmem_lock_o              = (r_state != S_IDLE) & w_is_amo;
  assign stall_o                  = (r_state != S_IDLE) | (req_valid_i & ~r_done);
  assign done_o                   = r_done;
  assign done_data_o              = r_done_data;
  assign done_rd_o                = r_done_rd;
  assign xcpt_valid_o             = r_xcpt_valid;
  assign xcpt_code_o              = r_xcpt_code;

endmodule
`default_nettype wire
